tx_sender_arbiter: RTL and testbench



---
 rtl/tx_arb_pkg.sv | 24 ++
 rtl/tx_sender_arbiter_rr_priority_pick.sv | 28 ++
 rtl/tx_sender_arbiter.sv | 165 ++++++++++++++++
 tb/tb_tx_sender_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// Shared types and helpers for the UART sender arbiter.
package tx_arb_pkg;

    // Arbiter FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    // Number of UART bytes that fit in one data word
    function automatic int unsigned max_bytes(input int unsigned word_size,
                                              input int unsigned data_width);
        return word_size / data_width;
    endfunction

    // A byte count is legal when it is 1..max_b
    function automatic logic size_legal(input int unsigned size,
                                        input int unsigned max_b);
        return (size != 0) && (size <= max_b);
    endfunction

endpackage

// File: rtl/tx_sender_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request after last, wrapping.
module rr_priority_pick #(
    parameter int unsigned N = 3,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] winner,
    output logic         found
);

    logic [W-1:0] cand;

    // Scan from farthest offset to nearest so the nearest hit is kept
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = int'(N); i > 0; i--) begin
            cand = W'((32'(last) + 32'(i)) % N);
            if (req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_sender_arbiter.sv
// Round-robin sharing of the UART status/data sender between requesters.
module tx_sender_arbiter
    import tx_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = 3,
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned SIZE_WORD      = 3,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned GRANT_W        = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WORD_SIZE-1:0] req_data,
    input  logic [N_REQ*SIZE_WORD-1:0] req_size,
    output logic [N_REQ-1:0]           req_ack,
    output logic                       req_err,
    input  logic                       busy_sender,
    output logic                       valid_data,
    output logic [WORD_SIZE-1:0]       data_to_send,
    output logic [SIZE_WORD-1:0]       size_of_data,
    output logic [GRANT_W-1:0]         grant_id,
    output logic                       active,
    input  logic                       err_clr,
    output logic                       timeout_err,
    output logic                       size_err
);

    localparam int unsigned MAX_B = max_bytes(WORD_SIZE, DATA_WIDTH);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    arb_state_t           state_q, state_d;
    logic [GRANT_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 vd_q, vd_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic [SIZE_WORD-1:0] size_q, size_d;
    logic [GRANT_W-1:0]   gid_q, gid_d;
    logic                 act_q;
    logic                 terr_q, terr_d;
    logic                 serr_q, serr_d;

    logic [GRANT_W-1:0]   win;
    logic                 found;
    logic [WORD_SIZE-1:0] win_data;
    logic [SIZE_WORD-1:0] win_size;

    rr_priority_pick #(
        .N (N_REQ),
        .W (GRANT_W)
    ) u_pick (
        .req    (req_valid),
        .last   (last_q),
        .winner (win),
        .found  (found)
    );

    // Word and byte count of the current round-robin winner
    assign win_data = WORD_SIZE'(req_data >> (32'(win) * WORD_SIZE));
    assign win_size = SIZE_WORD'(req_size >> (32'(win) * SIZE_WORD));

    // Next-state and next-output logic; arbitration is held off during an ack cycle
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        err_d   = 1'b0;
        vd_d    = 1'b0;
        data_d  = data_q;
        size_d  = size_q;
        gid_d   = gid_q;
        terr_d  = terr_q & ~err_clr;
        serr_d  = serr_q & ~err_clr;

        unique case (state_q)
            ST_IDLE: begin
                if (found && !busy_sender && !(|ack_q)) begin
                    if (size_legal(32'(win_size), MAX_B)) begin
                        data_d  = win_data;
                        size_d  = win_size;
                        gid_d   = win;
                        vd_d    = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        ack_d  = N_REQ'(1) << win;
                        err_d  = 1'b1;
                        serr_d = 1'b1;
                        last_d = win;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (busy_sender) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2)) begin
                    ack_d   = N_REQ'(1) << gid_q;
                    err_d   = 1'b1;
                    terr_d  = 1'b1;
                    last_d  = gid_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!busy_sender) begin
                    ack_d   = N_REQ'(1) << gid_q;
                    last_d  = gid_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            last_q  <= GRANT_W'(N_REQ - 1);
            cnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            vd_q    <= 1'b0;
            data_q  <= '0;
            size_q  <= '0;
            gid_q   <= '0;
            act_q   <= 1'b0;
            terr_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            vd_q    <= vd_d;
            data_q  <= data_d;
            size_q  <= size_d;
            gid_q   <= gid_d;
            act_q   <= (state_d != ST_IDLE);
            terr_q  <= terr_d;
            serr_q  <= serr_d;
        end
    end

    assign req_ack      = ack_q;
    assign req_err      = err_q;
    assign valid_data   = vd_q;
    assign data_to_send = data_q;
    assign size_of_data = size_q;
    assign grant_id     = gid_q;
    assign active       = act_q;
    assign timeout_err  = terr_q;
    assign size_err     = serr_q;

endmodule

// File: tb/tb_tx_sender_arbiter.sv
// Directed + randomized bench for tx_sender_arbiter against a transaction model.
module tb_tx_sender_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned WS = 32;
    localparam int unsigned SW = 3;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 64;
    localparam int unsigned GW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*WS-1:0] req_data = '0;
    logic [N*SW-1:0] req_size = '0;
    logic [N-1:0]    req_ack;
    logic            req_err;
    logic            busy_sender = 1'b0;
    logic            valid_data;
    logic [WS-1:0]   data_to_send;
    logic [SW-1:0]   size_of_data;
    logic [GW-1:0]   grant_id;
    logic            active;
    logic            err_clr = 1'b0;
    logic            timeout_err;
    logic            size_err;

    int checks = 0;
    int errors = 0;

    // Transaction-level model of requesters and arbiter history
    int            m_last;
    logic [N-1:0]  pend;
    logic [WS-1:0] m_data [N];
    logic [SW-1:0] m_size [N];
    logic [WS-1:0] m_lat_data;
    logic [SW-1:0] m_lat_size;
    logic [GW-1:0] m_gid;

    tx_sender_arbiter #(
        .N_REQ(N), .WORD_SIZE(WS), .SIZE_WORD(SW), .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO), .GRANT_W(GW)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_size(req_size), .req_ack(req_ack), .req_err(req_err),
        .busy_sender(busy_sender), .valid_data(valid_data),
        .data_to_send(data_to_send), .size_of_data(size_of_data),
        .grant_id(grant_id), .active(active), .err_clr(err_clr),
        .timeout_err(timeout_err), .size_err(size_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int i, input logic [WS-1:0] d, input logic [SW-1:0] s);
        pend[i]             = 1'b1;
        m_data[i]           = d;
        m_size[i]           = s;
        req_valid[i]        = 1'b1;
        req_data[i*WS +: WS] = d;
        req_size[i*SW +: SW] = s;
    endtask

    task automatic drop(input int i);
        pend[i]      = 1'b0;
        req_valid[i] = 1'b0;
    endtask

    // Spec rule: first pending requester after the last one served, wrapping
    function automatic int pick();
        for (int k = 1; k <= int'(N); k++) begin
            int j;
            j = (m_last + k) % int'(N);
            if (pend[j]) return j;
        end
        return 0;
    endfunction

    function automatic bit legal_size(input logic [SW-1:0] s);
        return (s >= 1) && (s <= WS / DW);
    endfunction

    function automatic logic [SW-1:0] rand_size();
        int sel;
        if ($urandom_range(0, 4) == 0) begin
            sel = $urandom_range(0, 3);
            return (sel == 0) ? SW'(0) : SW'(4 + sel);
        end
        return SW'($urandom_range(1, 4));
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vd"},   valid_data, 0);
        chk({tag, "_ack"},  req_ack, 0);
        chk({tag, "_err"},  req_err, 0);
        chk({tag, "_data"}, data_to_send, 0);
        chk({tag, "_size"}, size_of_data, 0);
        chk({tag, "_gid"},  grant_id, 0);
        chk({tag, "_act"},  active, 0);
        chk({tag, "_terr"}, timeout_err, 0);
        chk({tag, "_serr"}, size_err, 0);
    endtask

    // Serve one request: sender raises busy dly cycles after valid_data, holds it len cycles
    task automatic serve(input int dly, input int len, output int w);
        logic [N-1:0] exp_ack;
        w = pick();
        exp_ack = '0;
        exp_ack[w] = 1'b1;
        tick();
        if (legal_size(m_size[w])) begin
            m_lat_data = m_data[w];
            m_lat_size = m_size[w];
            m_gid      = GW'(w);
            chk("issue_vd",   valid_data, 1);
            chk("issue_gid",  grant_id, m_gid);
            chk("issue_data", data_to_send, m_lat_data);
            chk("issue_size", size_of_data, m_lat_size);
            chk("issue_act",  active, 1);
            chk("issue_ack",  req_ack, 0);
            for (int d = 0; d < dly; d++) begin
                tick();
                chk("prebusy_vd",  valid_data, 0);
                chk("prebusy_ack", req_ack, 0);
            end
            busy_sender = 1'b1;
            for (int k = 0; k < len; k++) begin
                tick();
                chk("busy_vd",   valid_data, 0);
                chk("busy_ack",  req_ack, 0);
                chk("busy_data", data_to_send, m_lat_data);
            end
            busy_sender = 1'b0;
            tick();
            chk("done_ack", req_ack, exp_ack);
            chk("done_err", req_err, 0);
            chk("done_act", active, 0);
        end else begin
            chk("bad_ack",  req_ack, exp_ack);
            chk("bad_err",  req_err, 1);
            chk("bad_serr", size_err, 1);
            chk("bad_vd",   valid_data, 0);
            chk("bad_data", data_to_send, m_lat_data);
            chk("bad_gid",  grant_id, m_gid);
        end
        m_last = w;
        drop(w);
        tick();
        chk("post_vd",  valid_data, 0);
        chk("post_ack", req_ack, 0);
    endtask

    // Sender never raises busy; optionally clear errors in the cycle the timeout fires
    task automatic timeout_frame(input bit clr_at_end);
        int w;
        logic [N-1:0] exp_ack;
        w = pick();
        exp_ack = '0;
        exp_ack[w] = 1'b1;
        tick();
        m_lat_data = m_data[w];
        m_gid      = GW'(w);
        chk("to_vd",  valid_data, 1);
        chk("to_gid", grant_id, m_gid);
        for (int c = 1; c < int'(TO); c++) begin
            tick();
            chk("to_wait_ack", req_ack, 0);
            if (c == int'(TO) - 1 && clr_at_end) err_clr = 1'b1;
        end
        tick();
        err_clr = 1'b0;
        chk("to_ack",  req_ack, exp_ack);
        chk("to_err",  req_err, 1);
        chk("to_terr", timeout_err, 1);
        m_last = w;
        drop(w);
        tick();
        chk("to_post_ack", req_ack, 0);
    endtask

    initial begin
        int w;
        pend       = '0;
        m_last     = int'(N) - 1;
        m_lat_data = '0;
        m_lat_size = '0;
        m_gid      = '0;
        for (int i = 0; i < int'(N); i++) begin
            m_data[i] = '0;
            m_size[i] = '0;
        end

        // Reset values
        tick();
        tick();
        chk_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single request, sender busy 2 cycles after issue for 10 cycles
        raise(0, 32'hDEADBEEF, 3'd4);
        serve(2, 10, w);

        // All requesters continuously active with legal sizes
        for (int i = 0; i < int'(N); i++) raise(i, $urandom, SW'($urandom_range(1, 4)));
        for (int f = 0; f < 6; f++) begin
            serve($urandom_range(1, 4), $urandom_range(1, 8), w);
            raise(w, $urandom, SW'($urandom_range(1, 4)));
        end
        for (int i = 0; i < int'(N); i++) drop(i);
        tick();

        // Illegal sizes rejected, then a legal request is served
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_serr", size_err, 0);
        chk("clr_terr", timeout_err, 0);
        raise(1, $urandom, 3'd0);
        serve(1, 1, w);
        raise(1, $urandom, 3'd5);
        serve(1, 1, w);
        raise(2, $urandom, 3'd3);
        serve(1, 3, w);
        chk("serr_sticky", size_err, 1);

        // Timeouts, clear-vs-set priority
        raise(0, $urandom, 3'd4);
        timeout_frame(1'b0);
        raise(1, $urandom, 3'd2);
        timeout_frame(1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("terr_cleared", timeout_err, 0);
        chk("serr_cleared", size_err, 0);

        // Randomized request mixes
        for (int f = 0; f < 14; f++) begin
            for (int i = 0; i < int'(N); i++)
                if (!pend[i] && $urandom_range(0, 1) == 1) raise(i, $urandom, rand_size());
            if (pend == '0) raise($urandom_range(0, N - 1), $urandom, rand_size());
            serve($urandom_range(1, 4), $urandom_range(1, 6), w);
        end
        for (int i = 0; i < int'(N); i++) drop(i);
        tick();

        // Async reset while the sender is busy: no ack, round robin restarts at 0
        raise(0, $urandom, 3'd2);
        raise(2, $urandom, 3'd1);
        tick();
        chk("mid_vd", valid_data, 1);
        busy_sender = 1'b1;
        tick();
        tick();
        #3 rst = 1'b0;
        #1 chk_reset_outputs("midrst");
        for (int i = 0; i < int'(N); i++) drop(i);
        busy_sender = 1'b0;
        m_last     = int'(N) - 1;
        m_lat_data = '0;
        m_lat_size = '0;
        m_gid      = '0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rel_ack", req_ack, 0);
        chk("rel_vd",  valid_data, 0);
        for (int i = 0; i < int'(N); i++) raise(i, $urandom, SW'($urandom_range(1, 4)));
        serve(2, 3, w);
        for (int i = 0; i < int'(N); i++) drop(i);
        tick();

        // Sender busy at reset release: grant waits for busy to fall
        @(negedge clk);
        rst = 1'b0;
        busy_sender = 1'b1;
        m_last     = int'(N) - 1;
        m_lat_data = '0;
        m_lat_size = '0;
        m_gid      = '0;
        raise(1, $urandom, 3'd3);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("busyrel_vd",  valid_data, 0);
            chk("busyrel_act", active, 0);
        end
        busy_sender = 1'b0;
        serve(1, 4, w);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
